// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) feeding a FIFO read at I/O 0xE8/0xE9.
// rx_avail rises 1 clk after the stop sample; a pop lands 3 clk after rd_n rises; a push into a full FIFO is dropped and sets overrun.
module uart_rx #(
   parameter int CLK_HZ     = 27_000_000,
   parameter int BAUD       = 115200,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic       clk,
   input  logic       CRST,
   input  logic       rx,
   input  logic [7:0] addr,
   input  logic       rd_n,
   output logic [7:0] dout,
   output logic       rx_avail
);
   localparam int DIV   = (CLK_HZ + BAUD * 8) / (BAUD * 16);
   localparam int TW    = $clog2(DIV + 1);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t              state_q;
   logic [TW-1:0]       tick_q;
   logic [3:0]          ph_q;
   logic [2:0]          bit_q;
   logic [7:0]          shift_q;
   logic                perr_q, push_q, ferr_set_q;
   logic                rx_m_q, rx_s_q, rx_p_q, rd_m_q, rd_s_q, rd_p_q;
   logic                frame_err_q, overrun_q, par_err;
   logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [7:0]          mem [DEPTH];
   logic                tick, mid_bit, rx_fall, rd_rise, sel_dat, sel_sts;
   logic                empty, full, pop, push_ok, clr, ovr_set;
   logic [7:0]          status;

   always_ff @(posedge clk or negedge CRST) begin
      if (!CRST) begin
         {rx_m_q, rx_s_q, rx_p_q, rd_m_q, rd_s_q, rd_p_q} <= '1;
      end else begin
         rx_m_q <= rx;
         rx_s_q <= rx_m_q;
         rx_p_q <= rx_s_q;
         rd_m_q <= rd_n;
         rd_s_q <= rd_m_q;
         rd_p_q <= rd_s_q;
      end
   end

   assign rx_fall = rx_p_q & ~rx_s_q;
   assign rd_rise = rd_s_q & ~rd_p_q;
   assign tick    = (tick_q == TW'(DIV - 1));
   assign mid_bit = tick && (ph_q == 4'd15);

`ifdef UART_RX_PARITY_EN
   logic perr_set_q, par_err_q;
`endif

   always_ff @(posedge clk or negedge CRST) begin
      if (!CRST) begin
         state_q    <= S_IDLE;
         tick_q     <= '0;
         ph_q       <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         push_q     <= 1'b0;
         ferr_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_set_q <= 1'b0;
`endif
      end else begin
         push_q     <= 1'b0;
         ferr_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_set_q <= 1'b0;
`endif
         tick_q <= tick ? '0 : tick_q + 1'b1;
         if (tick) ph_q <= ph_q + 4'd1;
         case (state_q)
            S_IDLE: if (rx_fall) begin
               // Re-phase the oversampler so tick 8 lands mid start bit.
               tick_q  <= '0;
               ph_q    <= '0;
               state_q <= S_START;
            end
            S_START: if (tick && ph_q == 4'd7) begin
               ph_q    <= '0;
               bit_q   <= '0;
               state_q <= rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (mid_bit) begin
               shift_q <= {rx_s_q, shift_q[7:1]};
               bit_q   <= bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  perr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  state_q <= S_PARITY;
`else
                  state_q <= S_STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (mid_bit) begin
               perr_q  <= (^shift_q) ^ rx_s_q;
               state_q <= S_STOP;
            end
`endif
            S_STOP: if (mid_bit) begin
`ifdef UART_RX_PARITY_EN
               perr_set_q <= perr_q;
`endif
               if (!rx_s_q) begin
                  ferr_set_q <= 1'b1;
                  state_q    <= S_WAIT_HIGH;
               end else begin
                  push_q  <= ~perr_q;
                  state_q <= S_IDLE;
               end
            end
            S_WAIT_HIGH: if (rx_s_q) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign sel_dat  = (addr == 8'hE8);
   assign sel_sts  = (addr == 8'hE9);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                     (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
   assign pop      = rd_rise & sel_dat & ~empty;
   assign push_ok  = push_q & (~full | pop);
   assign ovr_set  = push_q & full & ~pop;
   assign clr      = rd_rise & sel_sts;
   assign wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push_ok};
   assign rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= shift_q;
   end

   always_ff @(posedge clk or negedge CRST) begin
      if (!CRST) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         // A set in the same cycle as a status-read clear must win.
         if (clr) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
         end
         if (ferr_set_q) frame_err_q <= 1'b1;
         if (ovr_set)    overrun_q   <= 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge CRST) begin
      if (!CRST)           par_err_q <= 1'b0;
      else if (perr_set_q) par_err_q <= 1'b1;
      else if (clr)        par_err_q <= 1'b0;
   end
   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

   assign rx_avail = ~empty;
   assign status   = {4'b0000, par_err, overrun_q, frame_err_q, rx_avail};

   always_comb begin
      dout = 8'hFF;
      if (sel_dat)      dout = empty ? 8'h00 : mem[rd_ptr_q[DEPTH_LOG2-1:0]];
      else if (sel_sts) dout = status;
   end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, hand-written corner sequences and random frames against a queue-based model.
module tb_uart_rx;
   localparam int BIT = 240;

   logic       clk  = 1'b0;
   logic       CRST = 1'b0;
   logic       rx   = 1'b1;
   logic       rd_n = 1'b1;
   logic [7:0] addr = 8'h00;
   logic [7:0] dout;
   logic       rx_avail;
   int         checks = 0;
   int         errors = 0;

   uart_rx dut (
      .clk(clk), .CRST(CRST), .rx(rx), .addr(addr),
      .rd_n(rd_n), .dout(dout), .rx_avail(rx_avail)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      bit         par_bad;
      bit         stop_bad;
      logic [7:0] exp_sts;
      logic [7:0] exp_dat;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] exp_q[$];
   bit         m_ferr, m_ovr, m_perr;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad,
                             input int stop_bits, input int per);
      rx = 1'b0;
      wait_clk(per);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_clk(per);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^d) ^ par_bad;
      wait_clk(per);
`endif
      rx = ~stop_bad;
      wait_clk(per * stop_bits);
      rx = 1'b1;
      wait_clk(40);
   endtask

   task automatic peek(input logic [7:0] a, output logic [7:0] d);
      @(posedge clk); #1;
      addr = a;
      @(negedge clk);
      d = dout;
      @(posedge clk); #1;
      addr = 8'h00;
   endtask

   task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
      @(posedge clk); #1;
      addr = a;
      rd_n = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      d = dout;
      @(posedge clk); #1;
      rd_n = 1'b1;
      wait_clk(5);
      addr = 8'h00;
   endtask

   function automatic logic [7:0] model_status();
`ifdef UART_RX_PARITY_EN
      return {4'b0000, m_perr, m_ovr, m_ferr, exp_q.size() != 0};
`else
      return {4'b0000, 1'b0, m_ovr, m_ferr, exp_q.size() != 0};
`endif
   endfunction

   initial begin
      logic [7:0] d;
      int         per;
      bit         sb, pb;

      vecs.push_back('{8'h00, 1'b0, 1'b0, 8'h01, 8'h00});
      vecs.push_back('{8'hFF, 1'b0, 1'b0, 8'h01, 8'hFF});
      vecs.push_back('{8'hA3, 1'b0, 1'b1, 8'h02, 8'h00});
      vecs.push_back('{8'h80, 1'b0, 1'b0, 8'h01, 8'h80});
`ifdef UART_RX_PARITY_EN
      vecs.push_back('{8'h07, 1'b1, 1'b0, 8'h08, 8'h00});
      vecs.push_back('{8'h07, 1'b0, 1'b0, 8'h01, 8'h07});
`endif

      // Reset then idle
      wait_clk(5);
      CRST = 1'b1;
      wait_clk(3);
      check("reset_avail", {7'b0, rx_avail}, 8'h00);
      peek(8'hE9, d); check("reset_sts", d, 8'h00);
      peek(8'hE8, d); check("reset_dat", d, 8'h00);
      peek(8'h12, d); check("other_addr", d, 8'hFF);

      // Single byte with pop latency
      send_frame(8'h55, 1'b0, 1'b0, 1, BIT);
      check("single_avail", {7'b0, rx_avail}, 8'h01);
      peek(8'hE9, d); check("single_sts", d, 8'h01);
      @(posedge clk); #1;
      addr = 8'hE8;
      rd_n = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("single_dat", dout, 8'h55);
      @(posedge clk); #1;
      rd_n = 1'b1;
      repeat (3) @(negedge clk);
      check("pop_2clk_avail", {7'b0, rx_avail}, 8'h01);
      @(negedge clk);
      check("pop_3clk_avail", {7'b0, rx_avail}, 8'h00);
      wait_clk(3);
      addr = 8'h00;

      // Vector table
      foreach (vecs[i]) begin
         send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop_bad, 1, BIT);
         cpu_read(8'hE9, d); check($sformatf("vec%0d_sts", i), d, vecs[i].exp_sts);
         cpu_read(8'hE8, d); check($sformatf("vec%0d_dat", i), d, vecs[i].exp_dat);
         cpu_read(8'hE9, d); check($sformatf("vec%0d_clr", i), d, 8'h00);
      end

      // FIFO fill and overrun
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1, BIT);
      peek(8'hE9, d); check("fill_sts", d, 8'h05);
      for (int i = 1; i <= 8; i++) begin
         cpu_read(8'hE8, d); check($sformatf("fill_dat%0d", i), d, 8'(i));
      end
      cpu_read(8'hE9, d); check("ovr_sts", d, 8'h04);
      cpu_read(8'hE9, d); check("ovr_clr", d, 8'h00);

      // Framing error with a 2-bit break, then a good byte
      send_frame(8'hA3, 1'b0, 1'b1, 2, BIT);
      send_frame(8'h3C, 1'b0, 1'b0, 1, BIT);
      peek(8'hE9, d); check("ferr_sts", d, 8'h03);
      cpu_read(8'hE8, d); check("ferr_dat", d, 8'h3C);
      cpu_read(8'hE9, d); check("ferr_rd", d, 8'h02);
      peek(8'hE9, d); check("ferr_clr", d, 8'h00);

      // Glitch of 4 ticks
      rx = 1'b0;
      wait_clk(60);
      rx = 1'b1;
      wait_clk(2 * BIT);
      check("glitch_avail", {7'b0, rx_avail}, 8'h00);
      peek(8'hE9, d); check("glitch_sts", d, 8'h00);
      send_frame(8'h5A, 1'b0, 1'b0, 1, BIT);
      cpu_read(8'hE8, d); check("glitch_next", d, 8'h5A);

      // Reset mid-frame
      rx = 1'b0;
      wait_clk(4 * BIT);
      CRST = 1'b0;
      rx   = 1'b1;
      wait_clk(5);
      CRST = 1'b1;
      wait_clk(BIT);
      check("midrst_avail", {7'b0, rx_avail}, 8'h00);
      send_frame(8'hC3, 1'b0, 1'b0, 1, BIT);
      cpu_read(8'hE8, d); check("midrst_dat", d, 8'hC3);
      peek(8'hE9, d); check("midrst_sts", d, 8'h00);

      // Random frames with baud skew against the model
      m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      for (int n = 0; n < 8; n++) begin
         logic [7:0] b;
         b   = 8'($urandom);
         per = $urandom_range(236, 244);
         sb  = ($urandom_range(0, 4) == 0);
`ifdef UART_RX_PARITY_EN
         pb  = ($urandom_range(0, 4) == 0);
`else
         pb  = 1'b0;
`endif
         send_frame(b, pb, sb, 1, per);
         if (sb) m_ferr = 1'b1;
         if (pb) m_perr = 1'b1;
         if (!sb && !pb) begin
            if (exp_q.size() == 8) m_ovr = 1'b1;
            else exp_q.push_back(b);
         end
         cpu_read(8'hE9, d); check($sformatf("rnd%0d_sts", n), d, model_status());
         m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            cpu_read(8'hE8, d);
            check($sformatf("rnd%0d_dat", n), d, (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00);
         end
      end
      while (exp_q.size() != 0) begin
         cpu_read(8'hE8, d); check("drain_dat", d, exp_q.pop_front());
      end
      peek(8'hE9, d); check("drain_sts", d, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
